// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared constants and types for the SPART bus interface
package spart_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DB_LO  = 2'b10;
  localparam logic [1:0] ADDR_DB_HI  = 2'b11;

  localparam int STAT_TBR    = 0;
  localparam int STAT_CNT_LO = 4;
  localparam int STAT_CNT_HI = 6;
  localparam int STAT_OVR    = 7;

  localparam logic [15:0] DIV_DEFAULT = 16'h1458;

  typedef enum logic {
    TX_EMPTY = 1'b0,
    TX_FULL  = 1'b1
  } tx_state_e;

endpackage

// File: rtl/spart_rx_fifo.sv
// rtl/spart_rx_fifo.sv - receive byte FIFO with an explicit occupancy count
// A push into a full FIFO still succeeds when a pop frees a slot on the same edge.
module spart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [7:0]               push_data_i,
  input  logic                     pop_i,
  output logic [7:0]               head_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_pop, do_push;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & ~do_push;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/spart_bus_if.sv
// rtl/spart_bus_if.sv - SPART CPU register interface: RX FIFO, TX holding register, baud divisor
module spart_bus_if
  import spart_pkg::*;
#(
  parameter int          RX_DEPTH  = 4,
  parameter logic [15:0] DIV_RESET = DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iocs,
  input  logic        iorw,
  input  logic [1:0]  ioaddr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  input  logic [7:0]  rx_data,
  input  logic        rda,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic [15:0] divisor,
  output logic        div_load,
  output logic        irq
);

  logic rd, wr;
  logic rda_q, rx_push;
  logic rx_ovr_q;
  logic [7:0] rx_head;
  logic rx_empty, rx_full, rx_drop;
  logic [$clog2(RX_DEPTH):0] rx_count;

  tx_state_e   tx_state_q;
  logic [7:0]  tx_hold_q, tx_data_q;
  logic        tx_start_q;
  logic [15:0] divisor_q;
  logic        div_load_q;
  logic        tbr;
  logic [7:0]  status;

  assign rd = iocs & iorw;
  assign wr = iocs & ~iorw;

  // One push per rising edge of rda, however long it stays high.
  assign rx_push = rda & ~rda_q;

  spart_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (rx_push),
    .push_data_i (rx_data),
    .pop_i       (rd && ioaddr == ADDR_DATA),
    .head_o      (rx_head),
    .empty_o     (rx_empty),
    .full_o      (rx_full),
    .count_o     (rx_count),
    .drop_o      (rx_drop)
  );

  assign irq = ~rx_empty;
  assign tbr = (tx_state_q == TX_EMPTY);

  always_comb begin
    status = 8'h00;
    status[STAT_OVR] = rx_ovr_q;
    status[STAT_CNT_HI:STAT_CNT_LO] = 3'(rx_count);
    status[STAT_TBR] = tbr;
  end

  always_comb begin
    rdata = 8'h00;
    if (rd) begin
      case (ioaddr)
        ADDR_DATA:   rdata = rx_empty ? 8'h00 : rx_head;
        ADDR_STATUS: rdata = status;
        ADDR_DB_LO:  rdata = divisor_q[7:0];
        ADDR_DB_HI:  rdata = divisor_q[15:8];
        default:     rdata = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rda_q      <= 1'b0;
      rx_ovr_q   <= 1'b0;
      divisor_q  <= DIV_RESET;
      div_load_q <= 1'b0;
    end else begin
      rda_q      <= rda;
      div_load_q <= wr & ioaddr[1];
      if (wr && ioaddr == ADDR_DB_LO) divisor_q[7:0]  <= wdata;
      if (wr && ioaddr == ADDR_DB_HI) divisor_q[15:8] <= wdata;
      if (rx_drop)                           rx_ovr_q <= 1'b1;
      else if (rd && ioaddr == ADDR_STATUS)  rx_ovr_q <= 1'b0;
    end
  end

  // FULL lasts through the tx_start cycle so tbr rises only after the launch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= TX_EMPTY;
      tx_hold_q  <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
    end else begin
      case (tx_state_q)
        TX_EMPTY: begin
          if (wr && ioaddr == ADDR_DATA) begin
            tx_hold_q  <= wdata;
            tx_state_q <= TX_FULL;
            if (!tx_busy) begin
              tx_start_q <= 1'b1;
              tx_data_q  <= wdata;
            end
          end
        end
        TX_FULL: begin
          if (tx_start_q) begin
            tx_start_q <= 1'b0;
            tx_state_q <= TX_EMPTY;
          end else if (!tx_busy) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= tx_hold_q;
          end
        end
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign divisor  = divisor_q;
  assign div_load = div_load_q;

endmodule

// File: tb/tb_spart_bus_if.sv
// tb/tb_spart_bus_if.sv - scoreboard bench for spart_bus_if against a queue-based reference model
module tb_spart_bus_if;

  localparam int DEPTH = 4;

  logic        clk, rst, iocs, iorw, rda, tx_busy;
  logic [1:0]  ioaddr;
  logic [7:0]  wdata, rdata, rx_data, tx_data;
  logic        tx_start, div_load, irq;
  logic [15:0] divisor;

  spart_bus_if #(.RX_DEPTH(DEPTH), .DIV_RESET(16'h1458)) dut (
    .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .wdata(wdata), .rdata(rdata), .rx_data(rx_data), .rda(rda),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .divisor(divisor), .div_load(div_load), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  rdata;
    logic        irq;
    logic        start;
    logic [7:0]  txd;
    logic        dload;
    logic [15:0] div;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_miss = 0;

  // Reference model: FIFO contents as a queue, TX as idle/waiting/launching.
  logic [7:0]  mq[$];
  logic        m_ovr;
  int          m_phase;
  logic [7:0]  m_held;
  logic [15:0] m_div;
  logic        m_dl;
  logic        m_rda_prev;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovr = 1'b0; m_phase = 0; m_held = 8'h00;
    m_div = 16'h1458; m_dl = 1'b0; m_rda_prev = 1'b0;
  endtask

  task automatic step(input logic cs, input logic rw, input logic [1:0] a, input logic [7:0] wd,
                      input logic r_in, input logic [7:0] rxd, input logic busy);
    exp_t e;
    logic [7:0] tmp;
    logic push, ovr_new;
    @(posedge clk); #1;
    iocs = cs; iorw = rw; ioaddr = a; wdata = wd; rda = r_in; rx_data = rxd; tx_busy = busy;
    e.rdata = 8'h00;
    if (cs && rw) begin
      case (a)
        2'd0: e.rdata = (mq.size() > 0) ? mq[0] : 8'h00;
        2'd1: e.rdata = {m_ovr, 3'(mq.size()), 3'b000, (m_phase == 0)};
        2'd2: e.rdata = m_div[7:0];
        default: e.rdata = m_div[15:8];
      endcase
    end
    e.irq = (mq.size() != 0);
    e.start = (m_phase == 2);
    e.txd = m_held;
    e.dload = m_dl;
    e.div = m_div;
    exp_q.push_back(e);

    if (cs && rw && a == 2'd0 && mq.size() > 0) tmp = mq.pop_front();
    push = r_in && !m_rda_prev;
    m_rda_prev = r_in;
    ovr_new = 1'b0;
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(rxd);
      else ovr_new = 1'b1;
    end
    if (ovr_new) m_ovr = 1'b1;
    else if (cs && rw && a == 2'd1) m_ovr = 1'b0;
    case (m_phase)
      0: if (cs && !rw && a == 2'd0) begin m_held = wd; m_phase = busy ? 1 : 2; end
      1: if (!busy) m_phase = 2;
      default: m_phase = 0;
    endcase
    if (cs && !rw && a == 2'd2) m_div[7:0] = wd;
    if (cs && !rw && a == 2'd3) m_div[15:8] = wd;
    m_dl = cs && !rw && a[1];
  endtask

  task automatic idle(input int n, input logic busy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00, busy);
  endtask

  task automatic rd_reg(input logic [1:0] a);
    step(1'b1, 1'b1, a, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d, input logic busy);
    step(1'b1, 1'b0, a, d, 1'b0, 8'h00, busy);
  endtask

  task automatic rx_byte(input logic [7:0] d);
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, d, 1'b0);
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, d, 1'b0);
    idle(1, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rdata"},    16'(rdata),    16'h0000);
    chk({tag, "_tx_data"},  16'(tx_data),  16'h0000);
    chk({tag, "_tx_start"}, 16'(tx_start), 16'h0000);
    chk({tag, "_div_load"}, 16'(div_load), 16'h0000);
    chk({tag, "_irq"},      16'(irq),      16'h0000);
    chk({tag, "_divisor"},  divisor,       16'h1458);
  endtask

  always @(negedge clk) begin
    if (rst && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("rdata",    16'(rdata),    16'(mon_e.rdata));
      chk("irq",      16'(irq),      16'(mon_e.irq));
      chk("tx_start", 16'(tx_start), 16'(mon_e.start));
      if (mon_e.start) chk("tx_data", 16'(tx_data), 16'(mon_e.txd));
      chk("div_load", 16'(div_load), 16'(mon_e.dload));
      chk("divisor",  divisor,       mon_e.div);
    end
  end

  initial begin
    logic r_prev;
    int   r_run;
    logic busy_r;
    int   op;
    rst = 1'b0; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'd0; wdata = 8'h00;
    rda = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("por");
    @(negedge clk); rst = 1'b1;

    rd_reg(2'd1);

    rx_byte(8'hA5);
    idle(1, 1'b0);
    rd_reg(2'd0);
    rd_reg(2'd1);

    for (int i = 1; i <= 5; i++) rx_byte(8'(i));
    rd_reg(2'd1);
    for (int i = 0; i < 4; i++) rd_reg(2'd0);
    rd_reg(2'd1);

    for (int i = 1; i <= 4; i++) rx_byte(8'(i));
    step(1'b1, 1'b1, 2'd0, 8'h00, 1'b1, 8'h09, 1'b0);
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 8'h09, 1'b0);
    idle(1, 1'b0);
    rd_reg(2'd1);
    for (int i = 0; i < 4; i++) rd_reg(2'd0);
    rd_reg(2'd1);

    wr_reg(2'd0, 8'h3C, 1'b1);
    idle(2, 1'b1);
    step(1'b1, 1'b1, 2'd1, 8'h00, 1'b0, 8'h00, 1'b1);
    wr_reg(2'd0, 8'h77, 1'b1);
    idle(2, 1'b1);
    idle(4, 1'b0);
    rd_reg(2'd1);
    wr_reg(2'd0, 8'h5A, 1'b0);
    idle(3, 1'b0);

    wr_reg(2'd2, 8'h34, 1'b0);
    wr_reg(2'd3, 8'h12, 1'b0);
    idle(1, 1'b0);
    rd_reg(2'd2);
    rd_reg(2'd3);

    rx_byte(8'h11);
    rx_byte(8'h22);
    wr_reg(2'd0, 8'h55, 1'b1);
    idle(1, 1'b1);
    @(negedge clk);
    #2;
    iocs = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_outputs("mid");
    exp_q.delete();
    model_reset();
    tx_busy = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    rd_reg(2'd1);

    r_prev = 1'b0; r_run = 0; busy_r = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      logic r_now;
      if (r_prev) r_now = (r_run < 2) && ($urandom_range(0, 1) == 1);
      else        r_now = ($urandom_range(0, 3) == 0);
      r_run = r_now ? r_run + 1 : 0;
      r_prev = r_now;
      if ($urandom_range(0, 7) == 0) busy_r = ~busy_r;
      op = $urandom_range(0, 9);
      if (op < 3)
        step(1'b0, 1'b0, 2'd0, 8'h00, r_now, 8'($urandom), busy_r);
      else if (op < 8)
        step(1'b1, 1'b1, 2'($urandom_range(0, 3)), 8'h00, r_now, 8'($urandom), busy_r);
      else
        step(1'b1, 1'b0, 2'($urandom_range(0, 3)), 8'($urandom), r_now, 8'($urandom), busy_r);
    end
    idle(4, 1'b0);
    @(negedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
